// File: rtl/reflet_uart_rx_fifo.sv
// reflet_uart_rx_fifo
// Receive-side byte FIFO that sits behind the UART byte engine. Each rising
// edge of byte_done pushes byte_in into a circular buffer. The CPU reaches the
// buffer through four bus registers: STATUS, COUNT, DATA and CTRL.
// A one-cycle interrupt pulse tells software that data is waiting.
//
// Optional feature macro: REFLET_UART_RX_FIFO_THRESHOLD_EN
//   When it is defined, CTRL[8+depth_log2:8] holds an interrupt threshold
//   (reset value 1). The interrupt then fires when the occupancy reaches that
//   threshold instead of on the empty-to-one transition.
//   This layout needs wordsize >= 9 + depth_log2.
module reflet_uart_rx_fifo #(
  parameter int                        wordsize       = 16,
  parameter int                        base_addr_size = 16,
  parameter logic [base_addr_size-1:0] base_addr      = 16'hFF0C,
  parameter int                        depth_log2     = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [base_addr_size-1:0] addr,
  input  logic                      write_en,
  input  logic [wordsize-1:0]       data_in,
  output logic [wordsize-1:0]       data_out,
  input  logic [7:0]                byte_in,
  input  logic                      byte_done,
  output logic                      interrupt
);

  localparam int                    cnt_w     = depth_log2 + 1;
  localparam int                    depth     = 32'd1 << depth_log2;
  localparam logic [cnt_w-1:0]      depth_cnt = cnt_w'(depth);
  localparam logic [cnt_w-1:0]      zero_cnt  = cnt_w'(32'd0);
  localparam logic [cnt_w-1:0]      one_cnt   = cnt_w'(32'd1);
  localparam logic [depth_log2-1:0] zero_ptr  = depth_log2'(32'd0);
  localparam logic [depth_log2-1:0] one_ptr   = depth_log2'(32'd1);

  // Bus decode
  logic [base_addr_size-1:0] diff_s;
  logic                      selected_s;
  logic [1:0]                offset_s;
  logic                      bus_wr_s;
  logic                      pop_req_s;
  logic                      ctrl_wr_s;
  logic                      flush_s;
  logic                      ovf_clr_s;

  // UART edge capture
  logic                      byte_done_r;
  logic                      push_r;
  logic [7:0]                byte_r;

  // FIFO state
  logic [7:0]                mem_r [0:depth-1];
  logic [depth_log2-1:0]     wr_ptr_r;
  logic [depth_log2-1:0]     rd_ptr_r;
  logic [cnt_w-1:0]          count_r;
  logic                      ovf_r;
  logic                      ie_r;
  logic                      irq_r;

  // Next-state values
  logic [depth_log2-1:0]     wr_ptr_s;
  logic [depth_log2-1:0]     rd_ptr_s;
  logic [cnt_w-1:0]          count_s;
  logic                      ovf_s;
  logic                      ie_s;
  logic                      irq_s;
  logic                      pop_ok_s;
  logic                      push_ok_s;
  logic                      ovf_set_s;
  logic                      write_mem_s;
  logic [cnt_w-1:0]          eff_thr_s;

  // Read path
  logic [wordsize-1:0]       rd_data_s;
  logic [7:0]                head_s;
  logic                      unused_bits_s;

`ifdef REFLET_UART_RX_FIFO_THRESHOLD_EN
  logic [cnt_w-1:0]          thr_r;
  logic [cnt_w-1:0]          thr_s;
`endif

  // Only a few data_in bits carry meaning. The rest are folded here on purpose.
  assign unused_bits_s = ^data_in;

  // Address decode and bus write strobes.
  always_comb begin
    diff_s     = addr - base_addr;
    selected_s = enable && (addr >= base_addr) && (diff_s < base_addr_size'(3'd4));
    offset_s   = diff_s[1:0];
    bus_wr_s   = selected_s && write_en;
    pop_req_s  = bus_wr_s && (offset_s == 2'd2);
    ctrl_wr_s  = bus_wr_s && (offset_s == 2'd3);
    flush_s    = ctrl_wr_s && data_in[0];
    ovf_clr_s  = ctrl_wr_s && data_in[2];
  end

  // Register byte_done, and turn its rising edge into a one-cycle push that carries the byte sampled at that edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      byte_done_r <= 1'b0;
      push_r      <= 1'b0;
      byte_r      <= 8'h00;
    end else begin
      byte_done_r <= byte_done;
      push_r      <= byte_done && !byte_done_r;
      if (byte_done && !byte_done_r) begin
        byte_r <= byte_in;
      end else begin
        byte_r <= byte_r;
      end
    end
  end

  // FIFO next state: flush overrides everything, and a pop frees room for a same-cycle push.
  always_comb begin
    wr_ptr_s    = wr_ptr_r;
    rd_ptr_s    = rd_ptr_r;
    count_s     = count_r;
    ovf_set_s   = 1'b0;
    write_mem_s = 1'b0;
    pop_ok_s    = pop_req_s && (count_r != zero_cnt);
    push_ok_s   = push_r && ((count_r != depth_cnt) || pop_ok_s);
    if (flush_s) begin
      wr_ptr_s = zero_ptr;
      rd_ptr_s = zero_ptr;
      count_s  = zero_cnt;
    end else begin
      if (pop_ok_s) begin
        rd_ptr_s = rd_ptr_r + one_ptr;
      end else begin
        rd_ptr_s = rd_ptr_r;
      end
      if (push_ok_s) begin
        wr_ptr_s    = wr_ptr_r + one_ptr;
        write_mem_s = 1'b1;
      end else begin
        wr_ptr_s    = wr_ptr_r;
        write_mem_s = 1'b0;
      end
      ovf_set_s = push_r && !push_ok_s;
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_s = count_r + one_cnt;
        2'b01:   count_s = count_r - one_cnt;
        default: count_s = count_r;
      endcase
    end
    if (ovf_set_s) begin
      ovf_s = 1'b1;
    end else if (ovf_clr_s) begin
      ovf_s = 1'b0;
    end else begin
      ovf_s = ovf_r;
    end
  end

  // Control register fields and the interrupt condition on the occupancy transition.
  always_comb begin
    if (ctrl_wr_s) begin
      ie_s = data_in[1];
    end else begin
      ie_s = ie_r;
    end
`ifdef REFLET_UART_RX_FIFO_THRESHOLD_EN
    if (ctrl_wr_s) begin
      thr_s = data_in[8+depth_log2:8];
    end else begin
      thr_s = thr_r;
    end
    if (thr_r == zero_cnt) begin
      eff_thr_s = one_cnt;
    end else if (thr_r > depth_cnt) begin
      eff_thr_s = depth_cnt;
    end else begin
      eff_thr_s = thr_r;
    end
`else
    eff_thr_s = one_cnt;
`endif
    irq_s = ie_r && (count_r == (eff_thr_s - one_cnt)) && (count_s == eff_thr_s);
  end

  // State registers for pointers, occupancy, flags and the registered interrupt.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_r <= zero_ptr;
      rd_ptr_r <= zero_ptr;
      count_r  <= zero_cnt;
      ovf_r    <= 1'b0;
      ie_r     <= 1'b0;
      irq_r    <= 1'b0;
    end else begin
      wr_ptr_r <= wr_ptr_s;
      rd_ptr_r <= rd_ptr_s;
      count_r  <= count_s;
      ovf_r    <= ovf_s;
      ie_r     <= ie_s;
      irq_r    <= irq_s;
    end
  end

`ifdef REFLET_UART_RX_FIFO_THRESHOLD_EN
  // Interrupt threshold register. It resets to one so the default matches the non-threshold build.
  always_ff @(posedge clk) begin
    if (!reset) begin
      thr_r <= one_cnt;
    end else begin
      thr_r <= thr_s;
    end
  end
`endif

  // Byte storage. It has no reset because stale entries are never visible.
  always_ff @(posedge clk) begin
    if (write_mem_s) begin
      mem_r[wr_ptr_r] <= byte_r;
    end
  end

  // Combinational bus read mux. Values are zero-extended, and it returns zero when not addressed.
  always_comb begin
    rd_data_s = {wordsize{1'b0}};
    if (count_r == zero_cnt) begin
      head_s = 8'h00;
    end else begin
      head_s = mem_r[rd_ptr_r];
    end
    if (selected_s) begin
      case (offset_s)
        2'd0: rd_data_s[2:0] = {ovf_r, (count_r == depth_cnt), (count_r == zero_cnt)};
        2'd1: rd_data_s[cnt_w-1:0] = count_r;
        2'd2: rd_data_s[7:0] = head_s;
        2'd3: begin
          rd_data_s[1] = ie_r;
`ifdef REFLET_UART_RX_FIFO_THRESHOLD_EN
          rd_data_s[8+depth_log2:8] = thr_r;
`endif
        end
        default: rd_data_s = {wordsize{1'b0}};
      endcase
    end else begin
      rd_data_s = {wordsize{1'b0}};
    end
  end

  assign data_out  = rd_data_s;
  assign interrupt = irq_r;

endmodule

// File: tb/tb_reflet_uart_rx_fifo.sv
// Self-checking bench for reflet_uart_rx_fifo.
// Bytes pushed into the design are queued here as expected values.
// Each DATA read pops the queue and compares.
`timescale 1ns/1ps
module tb_reflet_uart_rx_fifo;

  localparam logic [15:0] base = 16'hFF0C;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [15:0] addr;
  logic        write_en;
  logic [15:0] data_in;
  logic [15:0] data_out;
  logic [7:0]  byte_in;
  logic        byte_done;
  logic        interrupt;

  int          errors   = 0;
  int          checks   = 0;
  int          irq_seen = 0;
  int          irq_base;
  logic [7:0]  exp_q[$];
  logic        model_ovf;
  logic [15:0] rd_val;
  logic [7:0]  exp_byte;

  always #5 clk = ~clk;

  reflet_uart_rx_fifo dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .addr      (addr),
    .write_en  (write_en),
    .data_in   (data_in),
    .data_out  (data_out),
    .byte_in   (byte_in),
    .byte_done (byte_done),
    .interrupt (interrupt)
  );

  // Count interrupt cycles, sampled mid-cycle.
  always @(negedge clk) begin
    if (interrupt === 1'b1) irq_seen++;
  end

  task automatic check_value(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_read(input logic [1:0] off, output logic [15:0] val);
    enable   = 1'b1;
    write_en = 1'b0;
    addr     = base + {14'd0, off};
    #1;
    val    = data_out;
    enable = 1'b0;
    tick(1);
  endtask

  task automatic bus_write(input logic [1:0] off, input logic [15:0] val);
    enable   = 1'b1;
    write_en = 1'b1;
    addr     = base + {14'd0, off};
    data_in  = val;
    tick(1);
    write_en = 1'b0;
    enable   = 1'b0;
  endtask

  // One byte_done pulse, and the matching scoreboard update.
  task automatic push_byte(input logic [7:0] b);
    byte_in   = b;
    byte_done = 1'b1;
    tick(1);
    byte_done = 1'b0;
    tick(2);
    if (exp_q.size() < 8) exp_q.push_back(b);
    else model_ovf = 1'b1;
  endtask

  task automatic check_status(input string tag);
    logic [15:0] exp_s;
    exp_s = {13'd0, model_ovf, (exp_q.size() == 8), (exp_q.size() == 0)};
    bus_read(2'd0, rd_val);
    check_value({tag, "_status"}, rd_val, exp_s);
    bus_read(2'd1, rd_val);
    check_value({tag, "_count"}, rd_val, exp_q.size());
  endtask

  task automatic pop_check(input string tag);
    bus_read(2'd2, rd_val);
    if (exp_q.size() == 0) exp_byte = 8'h00;
    else exp_byte = exp_q.pop_front();
    check_value(tag, rd_val, {8'h00, exp_byte});
    bus_write(2'd2, 16'h0000);
  endtask

  initial begin
    reset = 1'b0; enable = 1'b0; addr = 16'h0000; write_en = 1'b0;
    data_in = 16'h0000; byte_in = 8'h00; byte_done = 1'b0; model_ovf = 1'b0;
    tick(3);
    reset = 1'b1;
    tick(1);

    // Reset state
    irq_base = irq_seen;
    check_status("reset");
    bus_read(2'd2, rd_val);
    check_value("reset_data", rd_val, 16'h0000);
    bus_read(2'd3, rd_val);
`ifdef REFLET_UART_RX_FIFO_THRESHOLD_EN
    check_value("reset_ctrl", rd_val, 16'h0100);
`else
    check_value("reset_ctrl", rd_val, 16'h0000);
`endif
    tick(3);
    check_value("reset_irq", irq_seen - irq_base, 0);

    // Interrupt timing on a single push
    bus_write(2'd3, 16'h0002);
    irq_base  = irq_seen;
    byte_in   = 8'hA5;
    byte_done = 1'b1;
    tick(1);
    check_value("irq_early", interrupt, 1'b0);
    byte_done = 1'b0;
    tick(1);
    check_value("irq_pulse", interrupt, 1'b1);
    tick(1);
    check_value("irq_end", interrupt, 1'b0);
    exp_q.push_back(8'hA5);
    check_value("irq_count", irq_seen - irq_base, 1);
    check_status("single");
    pop_check("data_a5");

    // Held byte_done pushes once
    irq_base  = irq_seen;
    byte_in   = 8'h3C;
    byte_done = 1'b1;
    tick(100);
    byte_done = 1'b0;
    tick(2);
    exp_q.push_back(8'h3C);
    check_status("held");
    check_value("held_irq", irq_seen - irq_base, 1);
    pop_check("data_3c");

    // Overflow on the ninth byte, then drain and clear
    for (int i = 1; i <= 9; i++) push_byte(8'(i));
    check_status("ovf");
    for (int i = 0; i < 8; i++) pop_check("drain_ovf");
    check_status("ovf_empty");
    bus_write(2'd3, 16'h0004);
    model_ovf = 1'b0;
    check_status("ovf_clr");

    // Interrupt disabled: no pulse on an empty-to-one transition
    irq_base = irq_seen;
    push_byte(8'h10);
    check_value("irq_disabled", irq_seen - irq_base, 0);
    for (int i = 1; i < 8; i++) push_byte(8'h10 + 8'(i));
    check_status("full");

    // Push and pop together while full
    byte_in   = 8'h55;
    byte_done = 1'b1;
    tick(1);
    byte_done = 1'b0;
    enable    = 1'b1;
    write_en  = 1'b1;
    addr      = base + 16'd2;
    #1;
    exp_byte = exp_q.pop_front();
    check_value("full_pop_head", data_out, {8'h00, exp_byte});
    tick(1);
    write_en = 1'b0;
    enable   = 1'b0;
    exp_q.push_back(8'h55);
    tick(1);
    check_status("full_pushpop");
    for (int i = 0; i < 8; i++) pop_check("drain_55");

    // A push in the same cycle as a flush is discarded
    push_byte(8'h20);
    push_byte(8'h21);
    byte_in   = 8'h77;
    byte_done = 1'b1;
    tick(1);
    byte_done = 1'b0;
    bus_write(2'd3, 16'h0001);
    exp_q.delete();
    tick(1);
    check_status("flush");

    // Pop on empty is a no-op
    bus_write(2'd2, 16'h0000);
    check_status("pop_empty");

    // Reads outside the window, or with enable low, return zero
    enable = 1'b1;
    addr   = base + 16'd4;
    #1;
    check_value("unsel_above", data_out, 16'h0000);
    addr = base - 16'd1;
    #1;
    check_value("unsel_below", data_out, 16'h0000);
    enable = 1'b0;
    addr   = base;
    #1;
    check_value("disabled_rd", data_out, 16'h0000);
    tick(1);

    // Overflow set and clear in the same cycle: set wins
    for (int i = 0; i < 8; i++) push_byte(8'h30 + 8'(i));
    byte_in   = 8'h38;
    byte_done = 1'b1;
    tick(1);
    byte_done = 1'b0;
    bus_write(2'd3, 16'h0004);
    model_ovf = 1'b1;
    tick(1);
    check_status("ovf_set_wins");

    // Reset in the middle of operation
    bus_write(2'd3, 16'h0002);
    reset = 1'b0;
    tick(2);
    reset = 1'b1;
    exp_q.delete();
    model_ovf = 1'b0;
    tick(1);
    check_status("midreset");
    bus_read(2'd2, rd_val);
    check_value("midreset_data", rd_val, 16'h0000);

    // Threshold interrupt, or 0->1 interrupt when the feature is absent
    bus_write(2'd3, 16'h0302);
    bus_read(2'd3, rd_val);
    irq_base = irq_seen;
`ifdef REFLET_UART_RX_FIFO_THRESHOLD_EN
    check_value("thr_ctrl", rd_val, 16'h0302);
    push_byte(8'h41);
    push_byte(8'h42);
    check_value("thr_early", irq_seen - irq_base, 0);
    push_byte(8'h43);
    check_value("thr_fire", irq_seen - irq_base, 1);
`else
    check_value("thr_ctrl", rd_val, 16'h0002);
    push_byte(8'h41);
    check_value("thr_fire", irq_seen - irq_base, 1);
    push_byte(8'h42);
    push_byte(8'h43);
    check_value("thr_once", irq_seen - irq_base, 1);
`endif
    for (int i = 0; i < 3; i++) pop_check("drain_thr");
    check_status("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
